// File: rtl/axicb_wr_arbiter_if.sv
// Bundle of the per-master AW/W channels and the shared slave AW/W channels
// around axicb_wr_arbiter. The slave modport is the arbiter's view. The master
// modport is the view of whatever drives the masters and the slave port.
interface axicb_wr_arbiter_if #(
  parameter int MST_NB = 4,
  parameter int AWCH_W = 8,
  parameter int WCH_W  = 8
);

  // Per-master side
  logic [MST_NB-1:0]        i_awvalid;
  logic [MST_NB-1:0]        i_awready;
  logic [MST_NB*AWCH_W-1:0] i_awch;
  logic [MST_NB-1:0]        i_wvalid;
  logic [MST_NB-1:0]        i_wready;
  logic [MST_NB-1:0]        i_wlast;
  logic [MST_NB*WCH_W-1:0]  i_wch;

  // Shared slave side
  logic                     o_awvalid;
  logic                     o_awready;
  logic [AWCH_W-1:0]        o_awch;
  logic                     o_wvalid;
  logic                     o_wready;
  logic                     o_wlast;
  logic [WCH_W-1:0]         o_wch;
  logic                     o_timeout;

  modport slave (
    input  i_awvalid, i_awch, i_wvalid, i_wlast, i_wch, o_awready, o_wready,
    output i_awready, i_wready, o_awvalid, o_awch, o_wvalid, o_wlast, o_wch,
           o_timeout
  );

  modport master (
    output i_awvalid, i_awch, i_wvalid, i_wlast, i_wch, o_awready, o_wready,
    input  i_awready, i_wready, o_awvalid, o_awch, o_wvalid, o_wlast, o_wch,
           o_timeout
  );

endinterface

// File: rtl/axicb_wr_arbiter.sv
// Write-side arbiter for one crossbar slave port.
// AW requests from up to MST_NB masters are granted round-robin. Each granted
// master index is queued in an order FIFO. W beats are routed combinationally
// from the master at the FIFO head until its wlast handshake.
// Optional feature: define AXICB_WR_TIMEOUT_EN to add a sticky W-stall
// detector on o_timeout. Without it, o_timeout is tied low.
module axicb_wr_arbiter #(
  parameter int MST_NB         = 4,
  parameter int AWCH_W         = 8,
  parameter int WCH_W          = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               aclk,
  input  logic               aresetn,
  axicb_wr_arbiter_if.slave  bus
);

  localparam int IDX_W = (MST_NB > 1) ? $clog2(MST_NB) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Elaboration-time parameter sanity checks
  if (MST_NB < 1 || MST_NB > 4) begin : g_bad_mst_nb
    $error("axicb_wr_arbiter: MST_NB must be 1..4");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("axicb_wr_arbiter: FIFO_DEPTH must be a power of two in 2..16");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("axicb_wr_arbiter: TIMEOUT_CYCLES must fit the 8-bit stall counter");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [AWCH_W-1:0]  awch_q, awch_d;

  logic [IDX_W-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               fifo_full, fifo_empty;
  logic               push, pop;
  logic [IDX_W-1:0]   head;

  logic [IDX_W-1:0]   pick;
  logic               pick_vld;
  logic [MST_NB-1:0]  awready;
  logic [MST_NB-1:0]  wready;
  logic               wvalid, wlast;
  logic [WCH_W-1:0]   wch;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_mem_q[rd_ptr_q];

  // Round-robin search: first requester at or after rr_ptr, wrapping modulo MST_NB
  always_comb begin : rr_search
    int               idx;
    logic [IDX_W-1:0] sel;
    // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    sel      = '0;
    for (int i = 0; i < MST_NB; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= MST_NB) idx = idx - MST_NB;
      sel = IDX_W'(idx);
      if (!pick_vld && bus.i_awvalid[sel]) begin
        pick     = sel;
        pick_vld = 1'b1;
      end
    end
  end

  // AW FSM next state: IDLE accepts one master beat, GRANT presents it to the slave
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    awch_d   = awch_q;
    awready  = '0;
    push     = 1'b0;
    case (state_q)
      IDLE: begin
        // Full is checked only here, so an open grant always owns a free slot.
        if (pick_vld && !fifo_full) begin
          awready[pick] = 1'b1;
          grant_d       = pick;
          awch_d        = bus.i_awch[int'(pick)*AWCH_W +: AWCH_W];
          state_d       = GRANT;
        end
      end
      GRANT: begin
        if (bus.o_awready) begin
          push     = 1'b1;
          rr_ptr_d = (grant_q == IDX_W'(MST_NB - 1)) ? '0 : grant_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // AW FSM state and payload registers
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      awch_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      awch_q   <= awch_d;
    end
  end

  // Order FIFO storage
  always_ff @(posedge aclk) begin
    // NOTE: the storage array is not reset; count_q gates every read, so stale entries are never used.
    if (push) fifo_mem_q[wr_ptr_q] <= grant_q;
  end

  // Order FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // W routing from the FIFO-head master; nothing passes while the FIFO is empty
  always_comb begin
    wready = '0;
    wvalid = 1'b0;
    wlast  = 1'b0;
    wch    = '0;
    if (!fifo_empty) begin
      wvalid       = bus.i_wvalid[head];
      wlast        = bus.i_wlast[head];
      wch          = bus.i_wch[int'(head)*WCH_W +: WCH_W];
      wready[head] = bus.o_wready;
    end
  end

  assign pop = wvalid & bus.o_wready & wlast;

  assign bus.i_awready = awready;
  assign bus.o_awvalid = (state_q == GRANT);
  assign bus.o_awch    = awch_q;
  assign bus.i_wready  = wready;
  assign bus.o_wvalid  = wvalid;
  assign bus.o_wlast   = wlast;
  assign bus.o_wch     = wch;

`ifdef AXICB_WR_TIMEOUT_EN
  logic [7:0] stall_cnt_q;
  logic       timeout_q;

  // Stall counter: counts cycles a granted write waits on a W beat; the error flag is sticky
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      if (fifo_empty || (wvalid && bus.o_wready)) begin
        stall_cnt_q <= '0;
      end else if (!wvalid && (stall_cnt_q != 8'hFF)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (stall_cnt_q == 8'(TIMEOUT_CYCLES)) timeout_q <= 1'b1;
    end
  end

  assign bus.o_timeout = timeout_q;
`else
  assign bus.o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axicb_wr_arbiter.sv
// Self-checking bench for axicb_wr_arbiter (4 masters, FIFO depth 4).
// A cycle-by-cycle vector table covers single write, back-pressure, rr wrap
// and W ordering. Hand-written sequences cover round-robin order, FIFO full,
// W order blocking, simultaneous push/pop and the stall timeout.
module tb_axicb_wr_arbiter;

  localparam int MST_NB         = 4;
  localparam int AWCH_W         = 8;
  localparam int WCH_W          = 8;
  localparam int FIFO_DEPTH     = 4;
  localparam int TIMEOUT_CYCLES = 10;

`ifdef AXICB_WR_TIMEOUT_EN
  localparam logic TO_EXP = 1'b1;
`else
  localparam logic TO_EXP = 1'b0;
`endif

  logic aclk = 1'b0;
  logic aresetn;

  always #5 aclk = ~aclk;

  axicb_wr_arbiter_if #(.MST_NB(MST_NB), .AWCH_W(AWCH_W), .WCH_W(WCH_W)) bus ();

  axicb_wr_arbiter #(
    .MST_NB(MST_NB), .AWCH_W(AWCH_W), .WCH_W(WCH_W),
    .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  awvalid;
    logic        awready;
    logic [3:0]  wvalid;
    logic [3:0]  wlast;
    logic [31:0] wch;
    logic        wready;
    logic [3:0]  e_awready;
    logic        e_awvalid;
    logic [7:0]  e_awch;
    logic [3:0]  e_wready;
    logic        e_wvalid;
    logic        e_wlast;
    logic [7:0]  e_wch;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic [3:0] awv, input logic awr, input logic [3:0] wv, input logic [3:0] wl,
    input logic [31:0] wd, input logic wr,
    input logic [3:0] e_awr, input logic e_awv, input logic [7:0] e_awd,
    input logic [3:0] e_wr, input logic e_wv, input logic e_wl, input logic [7:0] e_wd);
    vec_t v;
    v.awvalid = awv;  v.awready = awr;  v.wvalid = wv;  v.wlast = wl;
    v.wch = wd;       v.wready = wr;
    v.e_awready = e_awr; v.e_awvalid = e_awv; v.e_awch = e_awd;
    v.e_wready = e_wr;   v.e_wvalid = e_wv;   v.e_wlast = e_wl; v.e_wch = e_wd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_awvalid = '0;
    bus.i_awch    = 32'hA3A2A1A0;
    bus.i_wvalid  = '0;
    bus.i_wlast   = '0;
    bus.i_wch     = '0;
    bus.o_awready = 1'b0;
    bus.o_wready  = 1'b0;
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Leaves the bench at posedge+1 of the first cycle out of reset.
  task automatic do_reset();
    idle_inputs();
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  // Raise a request and wait (bounded) for its i_awready; returns at
  // posedge+1 of the following GRANT cycle with the request dropped.
  task automatic aw_req(input logic [3:0] req, input string name);
    bus.i_awvalid = req;
    for (int c = 0; c < 8; c++) begin
      @(negedge aclk);
      if (bus.i_awready != 4'b0000) break;
      tick();
    end
    check(name, 32'(bus.i_awready), 32'(req));
    tick();
    bus.i_awvalid = '0;
  endtask

  function automatic int oh_idx(input logic [3:0] oh);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (oh[i]) r = i;
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int gcnt;
    int gidx [4];
    int gcyc [4];
    int exp_order [4];
    int nfree;

    exp_order = '{0, 1, 3, 0};

    vecs[0]  = mk(4'b0100, 1, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0100, 0, 8'h00, 4'b0000, 0, 0, 8'h00);
    vecs[1]  = mk(4'b0000, 1, 4'b0100, 4'b0000, 32'h00200000, 1, 4'b0000, 1, 8'hA2, 4'b0000, 0, 0, 8'h00);
    vecs[2]  = mk(4'b0000, 1, 4'b0100, 4'b0000, 32'h00200000, 1, 4'b0000, 0, 8'hA2, 4'b0100, 1, 0, 8'h20);
    vecs[3]  = mk(4'b0000, 1, 4'b0100, 4'b0000, 32'h00210000, 0, 4'b0000, 0, 8'hA2, 4'b0000, 1, 0, 8'h21);
    vecs[4]  = mk(4'b0000, 1, 4'b0100, 4'b0000, 32'h00210000, 1, 4'b0000, 0, 8'hA2, 4'b0100, 1, 0, 8'h21);
    vecs[5]  = mk(4'b0000, 1, 4'b0100, 4'b0000, 32'h00220000, 1, 4'b0000, 0, 8'hA2, 4'b0100, 1, 0, 8'h22);
    vecs[6]  = mk(4'b0000, 1, 4'b0100, 4'b0100, 32'h00230000, 1, 4'b0000, 0, 8'hA2, 4'b0100, 1, 1, 8'h23);
    vecs[7]  = mk(4'b1001, 1, 4'b0100, 4'b0000, 32'h00240000, 1, 4'b1000, 0, 8'hA2, 4'b0000, 0, 0, 8'h00);
    vecs[8]  = mk(4'b0001, 0, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 1, 8'hA3, 4'b0000, 0, 0, 8'h00);
    vecs[9]  = mk(4'b0001, 1, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 1, 8'hA3, 4'b0000, 0, 0, 8'h00);
    vecs[10] = mk(4'b0001, 1, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0001, 0, 8'hA3, 4'b1000, 0, 0, 8'h00);
    vecs[11] = mk(4'b0000, 1, 4'b0001, 4'b0001, 32'h00000030, 1, 4'b0000, 1, 8'hA0, 4'b1000, 0, 0, 8'h00);
    vecs[12] = mk(4'b0000, 1, 4'b1001, 4'b1001, 32'h33000030, 1, 4'b0000, 0, 8'hA0, 4'b1000, 1, 1, 8'h33);
    vecs[13] = mk(4'b0000, 1, 4'b0001, 4'b0001, 32'h00000030, 1, 4'b0000, 0, 8'hA0, 4'b0001, 1, 1, 8'h30);
    vecs[14] = mk(4'b0000, 1, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 0, 8'hA0, 4'b0000, 0, 0, 8'h00);

    // ---- Reset values, sampled while reset is held
    idle_inputs();
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("rst_o_awvalid", 32'(bus.o_awvalid), 32'd0);
    check("rst_o_awch",    32'(bus.o_awch),    32'd0);
    check("rst_i_awready", 32'(bus.i_awready), 32'd0);
    check("rst_o_wvalid",  32'(bus.o_wvalid),  32'd0);
    check("rst_o_wlast",   32'(bus.o_wlast),   32'd0);
    check("rst_i_wready",  32'(bus.i_wready),  32'd0);
    check("rst_o_timeout", 32'(bus.o_timeout), 32'd0);

    // ---- Table: single write from master 2, rr wrap 3 -> 0, W order 3 then 0
    do_reset();
    for (int v = 0; v < NVEC; v++) begin
      bus.i_awvalid = vecs[v].awvalid;
      bus.o_awready = vecs[v].awready;
      bus.i_wvalid  = vecs[v].wvalid;
      bus.i_wlast   = vecs[v].wlast;
      bus.i_wch     = vecs[v].wch;
      bus.o_wready  = vecs[v].wready;
      @(negedge aclk);
      check($sformatf("v%0d_i_awready", v), 32'(bus.i_awready), 32'(vecs[v].e_awready));
      check($sformatf("v%0d_o_awvalid", v), 32'(bus.o_awvalid), 32'(vecs[v].e_awvalid));
      check($sformatf("v%0d_o_awch", v),    32'(bus.o_awch),    32'(vecs[v].e_awch));
      check($sformatf("v%0d_i_wready", v),  32'(bus.i_wready),  32'(vecs[v].e_wready));
      check($sformatf("v%0d_o_wvalid", v),  32'(bus.o_wvalid),  32'(vecs[v].e_wvalid));
      check($sformatf("v%0d_o_wlast", v),   32'(bus.o_wlast),   32'(vecs[v].e_wlast));
      check($sformatf("v%0d_o_wch", v),     32'(bus.o_wch),     32'(vecs[v].e_wch));
      tick();
    end

    // ---- Round-robin: masters 0,1,3 request continuously -> 0,1,3,0
    do_reset();
    bus.o_awready = 1'b1;
    bus.o_wready  = 1'b1;
    bus.i_awvalid = 4'b1011;
    gcnt = 0;
    for (int c = 0; c < 12 && gcnt < 4; c++) begin
      @(negedge aclk);
      if (bus.i_awready != 4'b0000) begin
        gidx[gcnt] = oh_idx(bus.i_awready);
        gcyc[gcnt] = c;
        gcnt++;
      end
      tick();
    end
    check("rr_grant_count", 32'(gcnt), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < gcnt) begin
        check($sformatf("rr_grant%0d_idx", i), 32'(gidx[i]), 32'(exp_order[i]));
        check($sformatf("rr_grant%0d_spacing", i), 32'(gcyc[i] - gcyc[0]), 32'(2 * i));
      end
    end

    // ---- Full FIFO: four grants queued, no W yet, requests keep coming
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      check($sformatf("full_blocked_c%0d", c), 32'(bus.i_awready), 32'd0);
      tick();
    end
    bus.i_wvalid = 4'b0001;
    bus.i_wlast  = 4'b0001;
    bus.i_wch    = 32'h00000040;
    @(negedge aclk);
    check("full_pop_wready", 32'(bus.i_wready),  32'b0001);
    check("full_pop_wch",    32'(bus.o_wch),     32'h40);
    check("full_pop_still_blocked", 32'(bus.i_awready), 32'd0);
    tick();
    bus.i_wvalid = '0;
    bus.i_wlast  = '0;
    @(negedge aclk);
    check("full_regrant_m1", 32'(bus.i_awready), 32'b0010);
    tick();

    // ---- Order: grant 1 then 0; master 0 W waits for master 1's wlast
    do_reset();
    bus.o_awready = 1'b1;
    bus.o_wready  = 1'b1;
    aw_req(4'b0010, "ord_grant_m1");
    aw_req(4'b0001, "ord_grant_m0");
    bus.i_wvalid = 4'b0001;
    bus.i_wlast  = 4'b0001;
    bus.i_wch    = 32'h00000050;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      check($sformatf("ord_m0_blocked_c%0d", c), 32'(bus.i_wready[0]), 32'd0);
      check($sformatf("ord_no_wvalid_c%0d", c),  32'(bus.o_wvalid),    32'd0);
      tick();
    end
    bus.i_wvalid = 4'b0011;
    bus.i_wlast  = 4'b0001;
    bus.i_wch    = 32'h00006150;
    @(negedge aclk);
    check("ord_m1_beat0_wready", 32'(bus.i_wready), 32'b0010);
    check("ord_m1_beat0_wch",    32'(bus.o_wch),    32'h61);
    check("ord_m1_beat0_wlast",  32'(bus.o_wlast),  32'd0);
    tick();
    bus.i_wlast = 4'b0011;
    bus.i_wch   = 32'h00006250;
    @(negedge aclk);
    check("ord_m1_beat1_wready", 32'(bus.i_wready), 32'b0010);
    check("ord_m1_beat1_wch",    32'(bus.o_wch),    32'h62);
    check("ord_m1_beat1_wlast",  32'(bus.o_wlast),  32'd1);
    tick();
    bus.i_wvalid = 4'b0001;
    bus.i_wlast  = 4'b0001;
    @(negedge aclk);
    check("ord_m0_now_wready", 32'(bus.i_wready), 32'b0001);
    check("ord_m0_now_wch",    32'(bus.o_wch),    32'h50);
    tick();
    bus.i_wvalid = '0;
    bus.i_wlast  = '0;
    @(negedge aclk);
    check("ord_empty_wvalid", 32'(bus.o_wvalid), 32'd0);
    tick();

    // ---- Simultaneous push and pop at count 2
    do_reset();
    bus.o_awready = 1'b1;
    bus.o_wready  = 1'b1;
    aw_req(4'b0001, "pp_grant_m0");
    aw_req(4'b0010, "pp_grant_m1");
    aw_req(4'b0100, "pp_grant_m2");
    bus.i_wvalid = 4'b0001;
    bus.i_wlast  = 4'b0001;
    @(negedge aclk);
    check("pp_push_awvalid", 32'(bus.o_awvalid), 32'd1);
    check("pp_pop_wready",   32'(bus.i_wready),  32'b0001);
    check("pp_pop_wlast",    32'(bus.o_wlast),   32'd1);
    tick();
    bus.i_wvalid = '0;
    bus.i_wlast  = '0;
    @(negedge aclk);
    check("pp_new_head_m1", 32'(bus.i_wready), 32'b0010);
    tick();
    bus.i_awvalid = 4'b1000;
    nfree = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      if (bus.i_awready[3]) nfree++;
      tick();
    end
    check("pp_free_slots", 32'(nfree), 32'd2);
    bus.i_awvalid = '0;

    // ---- Stall timeout after one AW with no W beats
    do_reset();
    bus.o_awready = 1'b1;
    bus.o_wready  = 1'b1;
    aw_req(4'b0001, "to_grant_m0");
    tick();
    for (int j = 0; j < 15; j++) begin
      @(negedge aclk);
      if (j == 5)  check("to_early", 32'(bus.o_timeout), 32'd0);
      if (j == 14) check("to_raised", 32'(bus.o_timeout), 32'(TO_EXP));
      tick();
    end
    bus.i_wvalid = 4'b0001;
    bus.i_wlast  = 4'b0001;
    @(negedge aclk);
    check("to_w_resumes", 32'(bus.o_wvalid), 32'd1);
    tick();
    idle_inputs();
    repeat (3) tick();
    @(negedge aclk);
    check("to_sticky", 32'(bus.o_timeout), 32'(TO_EXP));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
